// File: rtl/mem_pkg.sv
// Shared data-memory geometry and the store-buffer entry type.
// The memory is word-addressed by Address[DMEM_IDX_HI:DMEM_IDX_LO].
package mem_pkg;

  localparam int WORD_W      = 32;
  localparam int DMEM_IDX_HI = 9;
  localparam int DMEM_IDX_LO = 2;
  localparam int IDX_W       = DMEM_IDX_HI - DMEM_IDX_LO + 1;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the live store-buffer entries.
// A later (younger) match in age order overrides an older one.
module sb_fwd_match
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic [IDX_W-1:0]  entry_idx  [DEPTH],
  input  logic [WORD_W-1:0] entry_data [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [CNT_W-1:0]  count,
  input  logic [IDX_W-1:0]  load_idx,
  output logic              hit,
  output logic [WORD_W-1:0] data
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Slot age relative to head decides whether it holds a live store.
      logic [PTR_W-1:0] offset;
      assign offset    = PTR_W'(gi) - head;
      assign match[gi] = ({1'b0, offset} < count) && (entry_idx[gi] == load_idx);
    end
  endgenerate

  logic [PTR_W-1:0] slot;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (match[slot]) begin
        hit  = 1'b1;
        data = entry_data[slot];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between the MEM stage and data memory: forwards to loads,
// drains to memory whenever the port is not taken by a load miss.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_MemWrite,
  input  logic              cpu_MemRead,
  input  logic [WORD_W-1:0] cpu_Address,
  input  logic [WORD_W-1:0] cpu_WriteData,
  output logic [WORD_W-1:0] cpu_ReadData,
  output logic              stall,
  output logic              empty,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic [WORD_W-1:0] mem_Address,
  output logic [WORD_W-1:0] mem_WriteData,
  input  logic [WORD_W-1:0] mem_ReadData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         entries_reg [DEPTH];
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [IDX_W-1:0]  entry_idx  [DEPTH];
  logic [WORD_W-1:0] entry_data [DEPTH];
  logic              fwd_hit;
  logic [WORD_W-1:0] fwd_data;
  logic              load_miss;
  logic              enq;
  logic              drain;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_view
      assign entry_idx[gi]  = entries_reg[gi].addr[DMEM_IDX_HI:DMEM_IDX_LO];
      assign entry_data[gi] = entries_reg[gi].data;
    end
  endgenerate

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_fwd (
    .entry_idx  (entry_idx),
    .entry_data (entry_data),
    .head       (head_reg),
    .count      (count_reg),
    .load_idx   (cpu_Address[DMEM_IDX_HI:DMEM_IDX_LO]),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );

  assign load_miss = cpu_MemRead && !fwd_hit;
  assign stall     = cpu_MemWrite && (count_reg == CNT_W'(DEPTH));
  assign enq       = cpu_MemWrite && !stall;
  // Drain is held off while reset is asserted so discarded stores never reach memory.
  assign drain     = reset && (count_reg != '0) && !load_miss;
  assign empty     = (count_reg == '0);

  always_comb begin
    mem_MemRead   = load_miss;
    mem_MemWrite  = drain;
    mem_Address   = cpu_Address;
    mem_WriteData = cpu_WriteData;
    if (!load_miss && (count_reg != '0)) begin
      mem_Address   = entries_reg[head_reg].addr;
      mem_WriteData = entries_reg[head_reg].data;
    end
  end

  always_comb begin
    cpu_ReadData = '0;
    if (cpu_MemRead)
      cpu_ReadData = fwd_hit ? fwd_data : mem_ReadData;
  end

  always_comb begin
    head_next  = drain ? head_reg + PTR_W'(1) : head_reg;
    tail_next  = enq ? tail_reg + PTR_W'(1) : tail_reg;
    count_next = count_reg + CNT_W'(enq) - CNT_W'(drain);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage carries no reset; liveness comes from head/count only.
  always_ff @(posedge clock) begin
    if (enq)
      entries_reg[tail_reg] <= '{addr: cpu_Address, data: cpu_WriteData};
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a pending-store queue plus a word memory
// model predict every cycle; a negedge monitor pops and compares.
module tb_store_buffer;
  import mem_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_MemWrite = 1'b0;
  logic        cpu_MemRead = 1'b0;
  logic [31:0] cpu_Address = '0;
  logic [31:0] cpu_WriteData = '0;
  logic [31:0] cpu_ReadData;
  logic        stall, empty;
  logic        mem_MemWrite, mem_MemRead;
  logic [31:0] mem_Address, mem_WriteData, mem_ReadData;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_MemWrite  (cpu_MemWrite),
    .cpu_MemRead   (cpu_MemRead),
    .cpu_Address   (cpu_Address),
    .cpu_WriteData (cpu_WriteData),
    .cpu_ReadData  (cpu_ReadData),
    .stall         (stall),
    .empty         (empty),
    .mem_MemWrite  (mem_MemWrite),
    .mem_MemRead   (mem_MemRead),
    .mem_Address   (mem_Address),
    .mem_WriteData (mem_WriteData),
    .mem_ReadData  (mem_ReadData)
  );

  always #5 clock = ~clock;

  // Data memory: async read, sync write.
  logic [31:0] dmem [256];
  assign mem_ReadData = dmem[mem_Address[9:2]];
  always @(posedge clock) if (mem_MemWrite) dmem[mem_Address[9:2]] = mem_WriteData;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    logic        stall;
    logic        empty;
    logic        mrd;
    logic        drain;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cpu_addr;
  } exp_t;

  st_t         pend [$];
  exp_t        exp_q [$];
  logic [31:0] mem_model [256];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // One cycle: drive inputs, predict DUT response from the pending-store model.
  task automatic cyc(input logic rst_n, input logic wr, input logic rd,
                     input logic [31:0] a, input logic [31:0] d, output logic stalled);
    exp_t e;
    logic hit;
    logic [31:0] fdata;
    @(posedge clock);
    #1;
    reset = rst_n; cpu_MemWrite = wr; cpu_MemRead = rd;
    cpu_Address = a; cpu_WriteData = d;
    hit = 1'b0; fdata = '0;
    foreach (pend[i]) if (pend[i].addr[9:2] == a[9:2]) begin hit = 1'b1; fdata = pend[i].data; end
    e.rd       = rd;
    e.rdata    = !rd ? 32'h0 : (hit ? fdata : mem_model[a[9:2]]);
    e.stall    = wr && (pend.size() == DEPTH);
    e.empty    = (pend.size() == 0);
    e.mrd      = rd && !hit;
    e.drain    = rst_n && (pend.size() != 0) && !(rd && !hit);
    e.addr     = e.drain ? pend[0].addr : 32'h0;
    e.wdata    = e.drain ? pend[0].data : 32'h0;
    e.cpu_addr = a;
    exp_q.push_back(e);
    stalled = e.stall;
    if (!rst_n) pend.delete();
    else begin
      if (e.drain) begin
        mem_model[pend[0].addr[9:2]] = pend[0].data;
        void'(pend.pop_front());
      end
      if (wr && !e.stall) pend.push_back('{addr: a, data: d});
    end
    $display("cyc rst=%0b wr=%0b rd=%0b a=%08h d=%08h exp_rdata=%08h stall=%0b drain=%0b pend=%0d",
             rst_n, wr, rd, a, d, e.rdata, e.stall, e.drain, pend.size());
  endtask

  task automatic idle(input int n);
    logic s;
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, s);
  endtask

  // Store held by the CPU until accepted, as a stalled pipeline would.
  task automatic store(input logic rd, input logic [31:0] a, input logic [31:0] d);
    logic s;
    int tries = 0;
    do begin
      cyc(1'b1, 1'b1, rd, a, d, s);
      tries++;
      rd = 1'b0;
    end while (s && tries < 2 * DEPTH + 4);
    if (s) begin
      failures++;
      $display("FAIL store_accept actual=stalled required=accepted addr=%08h", a);
    end
  endtask

  task automatic load(input logic [31:0] a);
    logic s;
    cyc(1'b1, 1'b0, 1'b1, a, 32'h0, s);
  endtask

  task automatic drain_all();
    int n = 0;
    while (pend.size() != 0 && n < 20) begin idle(1); n++; end
    idle(1);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("mem_MemWrite", 32'(mem_MemWrite), 32'(e.drain));
      chk("mem_MemRead", 32'(mem_MemRead), 32'(e.mrd));
      chk("cpu_ReadData", cpu_ReadData, e.rdata);
      if (e.drain) begin
        chk("drain_addr", mem_Address, e.addr);
        chk("drain_data", mem_WriteData, e.wdata);
      end
      if (e.mrd) chk("miss_addr", mem_Address, e.cpu_addr);
      if (mem_MemWrite && empty) begin
        checks++; failures++;
        $display("FAIL drain_when_empty actual=1 required=0");
      end
    end
  end

  initial begin
    logic s;
    logic [31:0] t, a;
    for (int i = 0; i < 256; i++) begin
      t = $urandom;
      dmem[i] = t;
      mem_model[i] = t;
    end
    dmem[8'h20] = 32'h12345678;
    mem_model[8'h20] = 32'h12345678;

    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, s);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, s);
    idle(2);

    // Forward, then drain.
    store(1'b0, 32'h10, 32'hDEADBEEF);
    load(32'h10);
    idle(3);

    // Youngest wins, aliasing compare.
    store(1'b0, 32'h20, 32'h1);
    store(1'b0, 32'h20, 32'h2);
    load(32'h20);
    load(32'h420);
    drain_all();

    // Fill while same-cycle load misses block drain, then stall and wrap.
    store(1'b1, 32'h0, 32'hA0);
    store(1'b1, 32'h4, 32'hA1);
    store(1'b1, 32'h8, 32'hA2);
    store(1'b1, 32'hC, 32'hA3);
    cyc(1'b1, 1'b1, 1'b1, 32'h50, 32'hA4, s);
    store(1'b0, 32'h50, 32'hA4);
    load(32'h50);
    drain_all();

    // Load misses hold off two pending stores.
    store(1'b0, 32'h100, 32'hB0);
    store(1'b1, 32'h104, 32'hB1);
    load(32'h80);
    load(32'h80);
    load(32'h80);
    drain_all();

    // Reset with three pending stores discards them.
    store(1'b1, 32'h200, 32'hC0);
    store(1'b1, 32'h204, 32'hC1);
    store(1'b1, 32'h208, 32'hC2);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, s);
    idle(2);
    load(32'h200);
    load(32'h204);
    load(32'h208);

    // Randomized traffic over a small aliased index range.
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      a = (t & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
      cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), a, $urandom, s);
    end
    drain_all();

    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
